alu_bus_sequencer: RTL
======================

Name: alu_bus_sequencer

Overview:
- Bus-side driver and consumer of the 16-bit ALU. Accepts an operation request and reads operand words off the shared data bus.
- Presents the operands, select and carry_in to the ALU, and enables the ALU onto the bus for exactly one cycle.
- Reads the result and flags back and holds them in a response register until the requester consumes them.
- Owns the persistent carry/zero flag register used for multi-word carry chaining.

Parameters:
- WIDTH, 16, data/bus width; the ALU carry_out is bit WIDTH of its internal result.
- OP_W, 5, width of the operation select code.
- NUM_OPS, 8, valid op codes are 0..NUM_OPS-1; codes at or above NUM_OPS are invalid.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  OP_W  ALU op code (0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not, 6 inc, 7 dec).
- req_use_carry  in  1  feed the stored carry flag to the ALU carry_in (meaningful for op 0 only).
- bus_valid  in  1  bus_data carries an operand word this cycle.
- bus_data  in  WIDTH  shared data bus (operand source and ALU result readback).
- clear_flags  in  1  synchronous clear of the flag register.
- alu_in_1  out  WIDTH  operand A to the ALU.
- alu_in_2  out  WIDTH  operand B to the ALU.
- alu_select  out  OP_W  ALU op select.
- alu_enable  out  1  ALU drives the bus.
- alu_carry_in  out  1  ALU carry in.
- alu_carry_out  in  1  ALU carry flag.
- alu_zero  in  1  ALU zero flag.
- resp_valid  out  1  result available.
- resp_ready  in  1  requester consumes the result.
- resp_data  out  WIDTH  result word.
- resp_err  out  1  request carried an invalid op.
- carry_flag  out  1  stored carry.
- zero_flag  out  1  stored zero.

Behaviour:
- Reset (async, rst_n low):
  - State returns to IDLE.
  - All registers and outputs are 0, except req_ready, which is 1.
  - Reset asserted mid-operation aborts the operation; no partial flag update occurs.
- States: IDLE, LOAD_A, LOAD_B, EXEC, DONE, ERR. All outputs are Moore, decoded from registered state.
- IDLE:
  - req_ready=1.
  - On req_valid, the op and use_carry are latched and op_b is cleared to 0.
  - Next state is LOAD_A if op < NUM_OPS, else ERR.
- LOAD_A: waits indefinitely for bus_valid. On the first bus_valid edge, op_a <= bus_data. Next state is LOAD_B for binary ops 0..4, EXEC for unary ops 5..7.
- LOAD_B: on the bus_valid edge, op_b <= bus_data, then EXEC. bus_valid in any other state is ignored.
- EXEC (exactly 1 cycle):
  - alu_enable=1.
  - alu_select = latched op.
  - alu_carry_in = use_carry & carry_flag & (op==0).
  - At the exiting edge: resp_data <= bus_data, carry_flag <= alu_carry_out, zero_flag <= alu_zero, resp_err <= 0. Next state is DONE.
- ERR: resp_data <= 0, resp_err <= 1, flags unchanged, alu_enable never asserted. Next state is DONE.
- DONE:
  - resp_valid=1.
  - resp_data and resp_err are held stable until resp_ready.
  - On resp_ready, return to IDLE. A new request can be accepted on the following cycle; there is no same-cycle turnaround.
- alu_in_1 = op_a and alu_in_2 = op_b at all times. alu_enable=0 outside EXEC; the bus is never driven by the ALU except in EXEC.
- clear_flags:
  - Clears carry_flag and zero_flag in any state.
  - If coincident with the EXEC capture edge, the clear wins.
  - resp_data is unaffected.
- Latency:
  - Minimum from request acceptance to resp_valid is 4 cycles for binary ops and 3 cycles for unary ops, given back-to-back bus_valid.
  - Operand waits stretch this without limit.

Decomposition:
- Shared package alu_pkg holds:
  - the op code constants (OP_ADD..OP_DEC);
  - the NUM_OPS value;
  - the state enumeration;
  - the is_binary_op function.
- No sub-module; single FSM plus datapath registers.

Test Plan:
- Add: op 0, bus words 0x00FF then 0x0001, ALU model attached -> alu_enable high exactly 1 cycle, resp_data=0x0100, carry=0, zero=0, resp_valid 4 cycles after accept.
- Sub borrow then carry chain:
  - Step 1: op 1 with 0x0001, 0x0002 -> resp_data=0xFFFF, carry_flag=1.
  - Step 2: op 0 with use_carry, 0xFFFF, 0x0000 -> alu_carry_in=1, resp_data=0x0000, carry=1, zero=1.
- Unary inc: op 6, one bus word 0x7FFF, plus an extra bus_valid 0x1234 during EXEC -> only one operand consumed, alu_in_2=0, resp_data=0x8000.
- Invalid op: op 9 -> resp_err=1, resp_data=0, alu_enable never high, flags unchanged from their prior values.
- Backpressure/clear:
  - resp_ready held low 5 cycles -> resp_data and resp_valid stable, req_ready=0 throughout.
  - clear_flags coincident with EXEC -> both flags 0.
- Reset mid-op: rst_n low during LOAD_B -> immediate return to IDLE, all outputs 0 except req_ready=1, and the next request completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, state encoding and op classification for the ALU bus sequencer.
// No logic latency; pure definitions.
// No flow control here.
package alu_pkg;

    localparam int NUM_OPS = 8;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_NOT = 5;
    localparam int OP_INC = 6;
    localparam int OP_DEC = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_DONE,
        ST_ERR
    } state_t;

    // Binary ops consume two bus words; the rest take only operand A.
    function automatic logic is_binary_op(input int unsigned op);
        return op <= OP_XOR;
    endfunction

endpackage

// File: rtl/alu_bus_sequencer.sv
// Sequences one ALU operation: latch request, read operands off the bus, run the ALU, hold the response.
// Latency: 4 cycles accept-to-resp_valid for binary ops, 3 for unary, 2 for invalid ops; stretched by operand waits.
// Backpressure: resp held in DONE until resp_ready; req_ready low for the whole transaction.
module alu_bus_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OP_W    = 5,
    parameter int NUM_OPS = alu_pkg::NUM_OPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  req_op,
    input  logic             req_use_carry,
    input  logic             bus_valid,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] alu_in_1,
    output logic [WIDTH-1:0] alu_in_2,
    output logic [OP_W-1:0]  alu_select,
    output logic             alu_enable,
    output logic             alu_carry_in,
    input  logic             alu_carry_out,
    input  logic             alu_zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic             carry_flag,
    output logic             zero_flag
);

    state_t           state_q;
    state_t           state_d;
    logic [OP_W-1:0]  op_q;
    logic             use_carry_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] resp_data_q;
    logic             resp_err_q;
    logic             carry_q;
    logic             zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = (32'(req_op) < NUM_OPS) ? ST_LOAD_A : ST_ERR;
                end
            end
            ST_LOAD_A: begin
                if (bus_valid) begin
                    state_d = is_binary_op(32'(op_q)) ? ST_LOAD_B : ST_EXEC;
                end
            end
            ST_LOAD_B: begin
                if (bus_valid) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_DONE;
            ST_ERR:  state_d = ST_DONE;
            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand/response datapath; op_b is zeroed on accept so unary ops see B=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            use_carry_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        use_carry_q <= req_use_carry;
                        op_b_q      <= '0;
                    end
                end
                ST_LOAD_A: begin
                    if (bus_valid) begin
                        op_a_q <= bus_data;
                    end
                end
                ST_LOAD_B: begin
                    if (bus_valid) begin
                        op_b_q <= bus_data;
                    end
                end
                ST_EXEC: begin
                    resp_data_q <= bus_data;
                    resp_err_q  <= 1'b0;
                end
                ST_ERR: begin
                    resp_data_q <= '0;
                    resp_err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // clear_flags takes priority over the EXEC capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (clear_flags) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            carry_q <= alu_carry_out;
            zero_q  <= alu_zero;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_DONE);
    assign alu_enable   = (state_q == ST_EXEC);
    assign alu_carry_in = alu_enable & use_carry_q & carry_q & (op_q == OP_W'(OP_ADD));
    assign alu_select   = op_q;
    assign alu_in_1     = op_a_q;
    assign alu_in_2     = op_b_q;
    assign resp_data    = resp_data_q;
    assign resp_err     = resp_err_q;
    assign carry_flag   = carry_q;
    assign zero_flag    = zero_q;

endmodule
